// File: rtl/niosii_system_st_symbol_packer.sv
// Avalon-ST symbol packer: gathers SYMBOLS_PER_BEAT narrow symbols into one wide beat
// with SOP/EOP/empty framing. Lane 0 sits in the MSBs of out_data.
module niosii_system_st_symbol_packer #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int EMPTY_WIDTH      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [SYMBOL_WIDTH-1:0]                in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_startofpacket,
  input  logic                                   in_endofpacket,
  output logic [SYMBOL_WIDTH*SYMBOLS_PER_BEAT-1:0] out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_startofpacket,
  output logic                                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]                 out_empty,
  output logic                                   sop_error
);

  localparam int W  = SYMBOL_WIDTH;
  localparam int N  = SYMBOLS_PER_BEAT;
  localparam int DW = W * N;
  localparam logic [EMPTY_WIDTH-1:0] LAST_LANE = EMPTY_WIDTH'(N - 1);

  // Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
  // valid never waits on ready; out_* hold steady while out_valid & !out_ready.
  logic [DW-1:0]          r_asm_data;
  logic [EMPTY_WIDTH-1:0] r_cnt;
  logic                   r_asm_sop;
  logic                   r_in_packet;
  logic [DW-1:0]          r_out_data;
  logic                   r_out_valid;
  logic                   r_out_sop;
  logic                   r_out_eop;
  logic [EMPTY_WIDTH-1:0] r_out_empty;
  logic                   r_sop_error;

  logic                   w_in_ready;
  logic                   w_acc;
  logic                   w_drop;
  logic                   w_restart;
  logic                   w_take;
  logic                   w_complete;
  logic [EMPTY_WIDTH-1:0] w_k;
  logic [DW-1:0]          w_merged;
  logic [EMPTY_WIDTH-1:0] w_empty;
  logic                   w_beat_sop;

  assign w_in_ready = !r_out_valid | out_ready;
  assign w_acc      = in_valid & w_in_ready;
  assign w_drop     = w_acc & !r_in_packet & !in_startofpacket;
  assign w_restart  = w_acc & in_startofpacket & (r_cnt != '0);
  assign w_take     = w_acc & !w_drop;
  // A mid-beat SOP throws away the partial beat and starts again at lane 0.
  assign w_k        = w_restart ? '0 : r_cnt;
  assign w_complete = w_take & ((w_k == LAST_LANE) | in_endofpacket);
  assign w_empty    = in_endofpacket ? (LAST_LANE - w_k) : '0;
  assign w_beat_sop = (w_k == '0) ? in_startofpacket : r_asm_sop;

  // Lanes below k keep assembled symbols, lane k takes the new one, lanes above are zero.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < N; i++) begin
      if (EMPTY_WIDTH'(i) < w_k)
        w_merged[W*(N-i)-1 -: W] = r_asm_data[W*(N-i)-1 -: W];
      else if (EMPTY_WIDTH'(i) == w_k)
        w_merged[W*(N-i)-1 -: W] = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_asm_data  <= '0;
      r_cnt       <= '0;
      r_asm_sop   <= 1'b0;
      r_in_packet <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_sop_error <= 1'b0;
    end else begin
      r_sop_error <= w_restart | w_drop;
      if (w_take) begin
        if (in_endofpacket)
          r_in_packet <= 1'b0;
        else if (in_startofpacket)
          r_in_packet <= 1'b1;
        if (w_complete) begin
          r_cnt      <= '0;
          r_asm_sop  <= 1'b0;
          r_asm_data <= '0;
        end else begin
          r_cnt      <= w_k + EMPTY_WIDTH'(1);
          r_asm_data <= w_merged;
          if (w_k == '0)
            r_asm_sop <= in_startofpacket;
        end
      end
      if (w_complete) begin
        r_out_data  <= w_merged;
        r_out_sop   <= w_beat_sop;
        r_out_eop   <= in_endofpacket;
        r_out_empty <= w_empty;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign out_data          = r_out_data;
  assign out_valid         = r_out_valid;
  assign out_startofpacket = r_out_sop;
  assign out_endofpacket   = r_out_eop;
  assign out_empty         = r_out_empty;
  assign sop_error         = r_sop_error;

endmodule

// File: tb/tb_niosii_system_st_symbol_packer.sv
// Bench for the symbol packer: directed framing/error/backpressure scenarios plus a
// randomized run, all scored against a packet-level model of the packing rules.
module tb_niosii_system_st_symbol_packer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int DW = W * N;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [1:0]    out_empty;
  logic          sop_error;

  niosii_system_st_symbol_packer #(
    .SYMBOL_WIDTH(W), .SYMBOLS_PER_BEAT(N), .EMPTY_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .sop_error(sop_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard: beat records are {sop, eop, empty[1:0], data[31:0]}
  logic [DW+3:0] exp_q[$];
  logic [DW+3:0] obs_q[$];

  // packet-level reference model
  logic [W-1:0] m_beat[$];
  bit           m_sop;
  bit           m_inpkt;

  task automatic model_reset();
    m_beat.delete();
    m_sop   = 0;
    m_inpkt = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_sym(input logic [W-1:0] d, input logic s, input logic e,
                           output bit err);
    logic [DW-1:0] word;
    logic [1:0]    emp;
    err = 0;
    if (!m_inpkt && !s) begin
      err = 1;
      return;
    end
    if (s) begin
      if (m_beat.size() != 0) err = 1;
      m_beat.delete();
      m_sop   = 1;
      m_inpkt = 1;
    end
    m_beat.push_back(d);
    if (e || m_beat.size() == N) begin
      word = '0;
      for (int j = 0; j < m_beat.size(); j++) word[W*(N-j)-1 -: W] = m_beat[j];
      emp = e ? 2'(N - m_beat.size()) : 2'd0;
      exp_q.push_back({m_sop, e, emp, word});
      m_beat.delete();
      m_sop = 0;
    end
    if (e) m_inpkt = 0;
  endtask

  // driver: one clock cycle of stimulus, with scoreboard checks of that cycle
  task automatic step(input logic v, input logic [W-1:0] d, input logic s,
                      input logic e, input logic r, output bit acc);
    logic [DW+3:0] got, want;
    bit err;
    in_valid = v; in_data = d; in_startofpacket = s; in_endofpacket = e; out_ready = r;
    #1;
    n_cmp++;
    if (in_ready !== (!out_valid | out_ready)) begin
      n_fail++;
      $display("FAIL in_ready_track: got %b want %b", in_ready, !out_valid | out_ready);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got = {out_startofpacket, out_endofpacket, out_empty, out_data};
      obs_q.push_back(got);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h want none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL beat_scoreboard: got %h want %h", got, want);
        end
      end
    end
    acc = (v === 1'b1) && (in_ready === 1'b1);
    err = 0;
    if (acc) model_sym(d, s, e, err);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (sop_error !== err) begin
      n_fail++;
      $display("FAIL sop_error: got %b want %b", sop_error, err);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic s, input logic e);
    bit acc;
    acc = 0;
    for (int t = 0; t < 50 && !acc; t++) step(1'b1, d, s, e, 1'b1, acc);
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: got no accept want accept for %h", d);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20; t++) begin
      if (exp_q.size() == 0 && out_valid !== 1'b1) break;
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending/valid=%b want 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    in_data = W'($urandom); out_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_valid: got %b want 0", out_valid);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
        out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0 ||
        out_empty !== 2'd0 || sop_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h s=%b e=%b emp=%0d err=%b want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
               out_empty, sop_error);
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_full_packet();
    obs_q.delete();
    for (int i = 1; i <= 8; i++) begin
      send(W'(i), i == 1, i == 8);
      if (i == 4) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL latency: got out_valid=%b want 1", out_valid);
        end
      end
    end
    drain();
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[0] !== 36'h8_0102_0304 || obs_q[1] !== 36'h4_0506_0708) begin
      n_fail++;
      $display("FAIL full_packet: got %0d beats %h %h want 801020304 405060708",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 36'h0,
               obs_q.size() > 1 ? obs_q[1] : 36'h0);
    end
  endtask

  task automatic test_short_tail();
    obs_q.delete();
    for (int i = 0; i < 6; i++) send(W'(8'hA0 + i), i == 0, i == 5);
    send(8'h55, 1'b1, 1'b1);
    drain();
    n_cmp++;
    if (obs_q.size() != 3 || obs_q[0] !== 36'h8_A0A1_A2A3 ||
        obs_q[1] !== 36'h6_A4A5_0000 || obs_q[2] !== 36'hF_5500_0000) begin
      n_fail++;
      $display("FAIL short_tail: got %0d beats last %h want 3 beats last F55000000",
               obs_q.size(), obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 36'h0);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [DW-1:0] held;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, W'(8'h21 + i), i == 0, 1'b0, 1'b0, acc);
    end
    held = out_data;
    n_cmp++;
    if (out_valid !== 1'b1 || held !== 32'h2122_2324) begin
      n_fail++;
      $display("FAIL bp_first_beat: got v=%b d=%h want 1 21222324", out_valid, held);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (acc || out_data !== held || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall: got acc=%b d=%h v=%b want 0 %h 1", acc, out_data, out_valid, held);
      end
    end
    for (int i = 0; i < 4; i++) send(W'(8'h25 + i), 1'b0, i == 3);
    drain();
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[0] !== 36'h8_2122_2324 || obs_q[1] !== 36'h4_2526_2728) begin
      n_fail++;
      $display("FAIL bp_stream: got %0d beats want 2 (821222324 425262728)", obs_q.size());
    end
  endtask

  task automatic test_errors();
    obs_q.delete();
    send(8'hE0, 1'b1, 1'b0);
    send(8'hE1, 1'b0, 1'b0);
    send(8'h11, 1'b1, 1'b0);
    n_cmp++;
    if (sop_error !== 1'b1) begin
      n_fail++;
      $display("FAIL err_mid_sop_pulse: got %b want 1", sop_error);
    end
    send(8'h12, 1'b0, 1'b0);
    n_cmp++;
    if (sop_error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: got %b want 0", sop_error);
    end
    send(8'h13, 1'b0, 1'b0);
    send(8'h14, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== 36'hC_1112_1314) begin
      n_fail++;
      $display("FAIL err_restart_beat: got %0d beats %h want 1 C11121314",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 36'h0);
    end
    send(8'h77, 1'b0, 1'b0);
    n_cmp++;
    if (sop_error !== 1'b1) begin
      n_fail++;
      $display("FAIL err_drop_pulse: got %b want 1", sop_error);
    end
    send(8'h88, 1'b1, 1'b1);
    drain();
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[1] !== 36'hF_8800_0000) begin
      n_fail++;
      $display("FAIL err_after_drop: got %0d beats want 2 last F88000000", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    apply_reset(2);
    @(negedge clk);
    send(8'h40, 1'b0, 1'b0);
    n_cmp++;
    if (sop_error !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got %b want 1", sop_error);
    end
    drain();
  endtask

  task automatic test_random();
    int sent, cycles, len;
    logic [W-1:0] d;
    bit acc;
    sent = 0; cycles = 0;
    while (sent < 2000 && cycles < 40000) begin
      len = $urandom_range(1, 17);
      for (int i = 0; i < len && cycles < 40000; i++) begin
        d = W'($urandom);
        acc = 0;
        while (!acc && cycles < 40000) begin
          step(1'($urandom_range(0, 1)), d, i == 0, i == len - 1,
               1'($urandom_range(0, 1)), acc);
          cycles++;
        end
        sent++;
      end
    end
    n_cmp++;
    if (cycles >= 40000) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d symbols want 2000", sent);
    end
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    out_ready = 1'b1;
    model_reset();
    test_reset();
    test_full_packet();
    test_short_tail();
    test_backpressure();
    test_errors();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/niosii_system_st_symbol_packer.md
# niosII_system_st_symbol_packer

Avalon-ST symbol packer that sits directly upstream of the data format adapter's buffer RAM. It accepts one SYMBOL_WIDTH symbol per cycle from the narrow camera/UART-side stream and assembles SYMBOLS_PER_BEAT symbols into one wide beat. Each beat carries packet framing (startofpacket, endofpacket, empty) and is presented on a ready/valid output stream. Backpressure propagates to the narrow side with zero bubbles when the downstream is ready.

## Interface
- SYMBOL_WIDTH, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per output beat (power of 2, ≥2).
- EMPTY_WIDTH, 2, log2(SYMBOLS_PER_BEAT).

- clk  in  1  clock; all state on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_data  in  SYMBOL_WIDTH  input symbol.
- in_valid  in  1  symbol valid.
- in_ready  out  1  packer can accept; transfer = in_valid & in_ready.
- in_startofpacket  in  1  first symbol of packet.
- in_endofpacket  in  1  last symbol of packet.
- out_data  out  SYMBOL_WIDTH*SYMBOLS_PER_BEAT  packed beat; symbol 0 in MSBs.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts; transfer = out_valid & out_ready.
- out_startofpacket  out  1  beat holds packet's first symbol.
- out_endofpacket  out  1  beat holds packet's last symbol.
- out_empty  out  EMPTY_WIDTH  unused symbol lanes in the EOP beat; 0 otherwise.
- sop_error  out  1  one-cycle pulse: SOP received mid-beat, or data received outside a packet.

## Operation
- State: assembly register asm_data, symbol counter cnt (0..SYMBOLS_PER_BEAT-1), asm_sop flag, in_packet flag, output register set (out_*).
- Accepted symbol at count k is written to lane k; lane k occupies bits [W*(N-k)-1 : W*(N-k-1)].
- A beat completes when k = N-1 or in_endofpacket=1. On completion:
  - The output register loads asm_data with the new symbol merged in; lanes >k are forced to 0.
  - out_startofpacket = asm_sop, or the current SOP when k=0.
  - out_endofpacket = in_endofpacket.
  - out_empty = in_endofpacket ? N-1-k : 0.
  - cnt clears and asm_sop clears.
- Non-completing symbols: cnt increments; asm_sop is set if the symbol carries SOP and k=0.
- Packet tracking: in_packet sets on an accepted SOP and clears on an accepted EOP.
  - SOP+EOP on the same symbol gives a single beat with SOP=EOP=1 and empty=N-1.
- Error handling:
  - An accepted SOP with cnt≠0: the partial beat is discarded, the new symbol becomes lane 0 of a fresh beat, and sop_error pulses.
  - An accepted symbol while in_packet=0 and no SOP: the symbol is dropped, cnt is unchanged, and sop_error pulses.
- in_ready = !out_valid | out_ready (combinational). Non-completing symbols obey the same rule, for a simple bench model.
- out_valid sets on completion. It clears on out_ready when no new completion occurs in the same cycle. When out_ready and a completion coincide, the output register reloads and out_valid stays 1.
- out_* are held stable while out_valid & !out_ready.

## Timing
- Reset (async assert, sync release) clears all state:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, sop_error=0.
  - cnt=0, asm_sop=0, in_packet=0.
  - in_ready therefore reads 1 once reset_n is high.
- Latency: a completing symbol accepted at edge n gives out_valid=1 in the cycle after edge n.
- Throughput: 1 symbol/cycle sustained with out_ready=1, i.e. one beat every N cycles (every cycle an EOP occurs can complete a short beat).
- Backpressure: out_ready low with out_valid high drops in_ready in the same cycle. No symbol is accepted until the beat drains.
- sop_error is registered and high for exactly the cycle after the offending edge.
- Reset mid-packet: the partial beat and the pending output beat are lost. The first post-reset accepted symbol must carry SOP.
- cnt wraps N-1 → 0 only via completion. in_valid=0 cycles leave all state unchanged.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=1 after release, no beat emitted.
- Full packet: 8 symbols 0x01..0x08, SOP on first and EOP on last, out_ready=1 → two beats:
  - beat 1: 0x01020304 with SOP=1, EOP=0, empty=0;
  - beat 2: 0x05060708 with EOP=1, empty=0.
- Short tail: 6 symbols 0xA0..0xA5 → beat 2 = 0xA4A50000 with EOP=1, empty=2. A single-symbol packet 0x55 gives 0x55000000 with SOP=EOP=1, empty=3.
- Backpressure: hold out_ready=0 after the first beat completes → in_ready=0 and out_data stable for 10 cycles. On release, the stream continues with no lost or duplicated symbols (checked against a scoreboard).
- Errors:
  - 2 symbols, then a new SOP with 0x11..0x14 → sop_error pulses 1 cycle and the beat is 0x11121314 with SOP=1.
  - A symbol without SOP after EOP → dropped, and sop_error pulses.
- Random: 2000 symbols with random in_valid/out_ready (50%) and random packet lengths 1..17 → output matches the reference packer model and in_ready tracks !out_valid|out_ready every cycle.
